dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory responder for the RISC-V core's load/store port. It accepts the request the decode/control path produces on `dmem_req`, `dmem_wr`, `dmem_size` and `dmem_zero_ex`, then performs a byte, half or word access on an internal word-organised RAM after a programmable number of wait states. It returns extended load data with a one-cycle `dmem_ready` pulse. The core stalls its PC and register-file write until that pulse.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DEPTH`, 1024: RAM depth in 32-bit words; must be a power of 2.
- `WAIT_CYCLES`, 1: wait states between accept and response; legal range 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `dmem_req`  in  1  access request; held high with all request fields stable until `dmem_ready`.
- `dmem_wr`  in  1  1 = store, 0 = load.
- `dmem_size`  in  2  `op_dmem_size`: BYTE, HALF or WORD.
- `dmem_zero_ex`  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- `dmem_addr`  in  ADDR_W  byte address.
- `dmem_wdata`  in  32  store data, right-aligned.
- `dmem_rdata`  out  32  load result; valid only while `dmem_ready` = 1.
- `dmem_ready`  out  1  single-cycle completion pulse.
- `dmem_err`  out  1  misaligned-access flag; valid with `dmem_ready`.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE, `dmem_req` = 1:
  - Latch wr, size, zero_ex, addr and wdata.
  - Next state is WAIT, with wait counter loaded to `WAIT_CYCLES` − 1, if `WAIT_CYCLES` > 0.
  - Next state is RESP if `WAIT_CYCLES` = 0.
- IDLE, `dmem_req` = 0: stay in IDLE.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
- RESP:
  - `dmem_ready` = 1; `dmem_rdata` and `dmem_err` are valid.
  - A store commits at the edge that ends RESP.
  - Next state is always IDLE.
- Word index = `addr[ADDR_W-1:2]` modulo `DEPTH`. Out-of-range addresses wrap silently.
- Store lanes:
  - BYTE writes lane `addr[1:0]` with `wdata[7:0]`.
  - HALF writes lanes {`addr[1]`,0} and {`addr[1]`,1} with `wdata[15:0]`.
  - WORD writes all four lanes.
  - Unselected lanes are unchanged.
- Load extraction:
  - BYTE returns lane `addr[1:0]`, extended to 32 bits.
  - HALF returns half `addr[1]`, extended to 32 bits.
  - WORD returns the whole word and ignores `zero_ex`.
  - Sign extension copies bit 7 (BYTE) or bit 15 (HALF).
- `dmem_size` = 2'b11 is treated as WORD.
- Stores return `dmem_rdata` = 0.
- The RAM array is not reset; its power-up contents are undefined.

## Timing
- Reset values: state IDLE, `dmem_ready` 0, `dmem_err` 0, `dmem_rdata` 0, counter 0.
- Latency: `dmem_ready` is high in the (`WAIT_CYCLES` + 1)-th cycle after the accepting edge.
- Throughput: at most one access per `WAIT_CYCLES` + 2 cycles. IDLE always takes at least one cycle between accesses.
- Read data is registered from the RAM.
- A load following a store to the same word, issued after the store's `dmem_ready`, returns the new data.
- `dmem_req` deasserted mid-access (a protocol violation) does not abort the access. The access still completes.
- Reset asserted mid-access returns the FSM to IDLE immediately and deasserts `dmem_ready`. An uncommitted store is discarded.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A misaligned access is HALF with `addr[0]` = 1, or WORD with `addr[1:0]` ≠ 0.
  - It completes with the normal latency, with `dmem_err` = 1 and `dmem_rdata` = 0.
  - A misaligned store writes nothing.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - Low address bits are forced to alignment: `addr[0]` cleared for HALF, `addr[1:0]` cleared for WORD.
  - `dmem_err` is tied to 0.

## Structure
- `risc_pkg` holds the shared definitions: existing `op_dmem_size` (OP_DMEM_BYTE/HALF/WORD), new `dmem_state_enum` (IDLE/WAIT/RESP), and `DMEM_WAIT_W` = 4.
- Sub-module `dmem_ram`: single-port array of `DEPTH` × 32 bits with a 4-bit byte-write enable and a registered read.
- Lane steering, extension and the FSM live in `dmem_ctrl`.

## Test plan
- Reset, `WAIT_CYCLES` = 1:
  - Store WORD 0xDEADBEEF at 0x10.
  - Expect `dmem_ready` 2 cycles after accept.
  - A subsequent load WORD from 0x10 returns 0xDEADBEEF.
- Byte loads from the word 0xDEADBEEF at 0x10:
  - Load BYTE at 0x13, sign-extended → 0xFFFFFFDE.
  - Load BYTE at 0x13, zero-extended (`zero_ex` = 1) → 0x000000DE.
  - Load BYTE at 0x10 → 0xFFFFFFEF.
- HALF store and load:
  - Store HALF 0x1234 at 0x12 over 0xDEADBEEF; word reads back 0x1234BEEF.
  - Load HALF at 0x12 → 0x00001234.
- `WAIT_CYCLES` = 0 and 3: `dmem_ready` arrives at 1 and 4 cycles after accept. No second pulse occurs while `dmem_req` stays low.
- With `DMEM_MISALIGN_TRAP_EN`:
  - Store WORD at 0x11 → `dmem_err` = 1 with `dmem_ready`.
  - Word 0x10 is unchanged.
- Without `DMEM_MISALIGN_TRAP_EN`: load WORD at 0x11 returns the word at 0x10, with `dmem_err` = 0.
- Mid-access reset:
  - Assert `rst_n` = 0 during WAIT of a store to 0x20.
  - `dmem_ready` drops at once and no write occurs.
  - A post-reset load from 0x20 returns the prior value.
- Wrap-around: with `DEPTH` = 1024, a store at 0x1000 aliases word 0.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared core definitions: access size, data-memory FSM states, wait counter width
package risc_pkg;

   typedef enum logic [1:0] {
      OP_DMEM_BYTE = 2'b00,
      OP_DMEM_HALF = 2'b01,
      OP_DMEM_WORD = 2'b10
   } op_dmem_size;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } dmem_state_enum;

   localparam int DMEM_WAIT_W = 4;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port DEPTH x 32 RAM, byte write enables, registered read
module dmem_ram #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - load/store responder with wait states; DMEM_MISALIGN_TRAP_EN enables misalignment trap
module dmem_ctrl
   import risc_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dmem_req,
   input  logic              dmem_wr,
   input  logic [1:0]        dmem_size,
   input  logic              dmem_zero_ex,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [31:0]       dmem_wdata,
   output logic [31:0]       dmem_rdata,
   output logic              dmem_ready,
   output logic              dmem_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? DMEM_WAIT_W'(WAIT_CYCLES - 1) : '0;

   dmem_state_enum          state, state_nxt;
   logic [DMEM_WAIT_W-1:0]  cnt;
   logic                    lat_wr;
   logic [1:0]              lat_size;
   logic                    lat_zex;
   logic [ADDR_W-1:0]       lat_addr;
   logic [31:0]             lat_wdata;

   logic                    is_byte, is_half, is_word, misalign;
   logic [1:0]              eff_lo;
   logic [3:0]              be, ram_we;
   logic [31:0]             wdata_lane, ram_rdata, load_val;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [IDX_W-1:0]        ram_addr;
   logic                    unused_addr_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dmem_req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         lat_wr    <= 1'b0;
         lat_size  <= '0;
         lat_zex   <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (state == IDLE && dmem_req) begin
         cnt       <= WAIT_LOAD;
         lat_wr    <= dmem_wr;
         lat_size  <= dmem_size;
         lat_zex   <= dmem_zero_ex;
         lat_addr  <= dmem_addr;
         lat_wdata <= dmem_wdata;
      end else if (state == WAIT && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign is_byte = (lat_size == OP_DMEM_BYTE);
   assign is_half = (lat_size == OP_DMEM_HALF);
   assign is_word = !is_byte && !is_half;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = (is_half && lat_addr[0]) || (is_word && lat_addr[1:0] != 2'b00);
   assign eff_lo   = lat_addr[1:0];
`else
   assign misalign = 1'b0;
   assign eff_lo   = is_word ? 2'b00 : (is_half ? {lat_addr[1], 1'b0} : lat_addr[1:0]);
`endif

   always_comb begin
      be         = 4'b1111;
      wdata_lane = lat_wdata;
      if (is_byte) begin
         be         = 4'b0001 << eff_lo;
         wdata_lane = {4{lat_wdata[7:0]}};
      end else if (is_half) begin
         be         = eff_lo[1] ? 4'b1100 : 4'b0011;
         wdata_lane = {2{lat_wdata[15:0]}};
      end
   end

   // In IDLE the RAM already reads the incoming address so a zero-wait access has data in RESP.
   assign ram_addr = (state == IDLE) ? dmem_addr[IDX_W+1:2] : lat_addr[IDX_W+1:2];
   assign ram_we   = (state == RESP && lat_wr && !misalign) ? be : 4'b0000;
   assign unused_addr_hi = ^lat_addr[ADDR_W-1:IDX_W+2];

   dmem_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_lane),
      .rdata (ram_rdata)
   );

   always_comb begin
      byte_sel = ram_rdata[{eff_lo, 3'b000} +: 8];
      half_sel = eff_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      load_val = ram_rdata;
      if (is_byte)      load_val = {{24{~lat_zex & byte_sel[7]}}, byte_sel};
      else if (is_half) load_val = {{16{~lat_zex & half_sel[15]}}, half_sel};
   end

   always_comb begin
      dmem_ready = 1'b0;
      dmem_err   = 1'b0;
      dmem_rdata = '0;
      if (state == RESP) begin
         dmem_ready = 1'b1;
         dmem_err   = misalign;
         if (!lat_wr && !misalign) dmem_rdata = load_val;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl at WAIT_CYCLES 1, 0 and 3
module tb_dmem_ctrl;
   import risc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic        wr;
   logic [1:0]  size;
   logic        zex;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rd [3];
   logic [2:0]  rdy;
   logic [2:0]  er;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .dmem_req(req[0]), .dmem_wr(wr), .dmem_size(size),
      .dmem_zero_ex(zex), .dmem_addr(addr), .dmem_wdata(wdata),
      .dmem_rdata(rd[0]), .dmem_ready(rdy[0]), .dmem_err(er[0]));

   dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .dmem_req(req[1]), .dmem_wr(wr), .dmem_size(size),
      .dmem_zero_ex(zex), .dmem_addr(addr), .dmem_wdata(wdata),
      .dmem_rdata(rd[1]), .dmem_ready(rdy[1]), .dmem_err(er[1]));

   dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .dmem_req(req[2]), .dmem_wr(wr), .dmem_size(size),
      .dmem_zero_ex(zex), .dmem_addr(addr), .dmem_wdata(wdata),
      .dmem_rdata(rd[2]), .dmem_ready(rdy[2]), .dmem_err(er[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Latency counts negedges after the accepting posedge until ready is seen.
   task automatic access(input int d, input logic w, input logic [1:0] sz, input logic zx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] r, output logic e, output int lat);
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      req[d] = 1'b1; wr = w; size = sz; zex = zx; addr = a; wdata = wd;
      @(posedge clk);
      lat = 0; r = '0; e = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         if (rdy[d] === 1'b1) begin
            seen = 1'b1; r = rd[d]; e = er[d];
         end
      end
      req[d] = 1'b0;
      chk("ready_seen", {31'b0, seen}, 32'd1);
      @(negedge clk);
      chk("ready_single_pulse", {31'b0, rdy[d]}, 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      int          lat;
      int          pulses;
      logic        seen;

      rst_n = 1'b0; req = '0; wr = 1'b0; size = '0; zex = 1'b0; addr = '0; wdata = '0;
      #3;
      chk("rst_ready", {29'b0, rdy}, 32'd0);
      chk("rst_err", {29'b0, er}, 32'd0);
      chk("rst_rdata", rd[0], 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      access(0, 1'b1, OP_DMEM_WORD, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat);
      chk("st_word_lat", lat, 32'd2);
      chk("st_word_rdata", r, 32'd0);
      chk("st_word_err", {31'b0, e}, 32'd0);
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h10, 32'h0, r, e, lat);
      chk("ld_word_lat", lat, 32'd2);
      chk("ld_word", r, 32'hDEADBEEF);

      access(0, 1'b0, OP_DMEM_BYTE, 1'b0, 32'h13, 32'h0, r, e, lat);
      chk("ld_byte13_sx", r, 32'hFFFFFFDE);
      access(0, 1'b0, OP_DMEM_BYTE, 1'b1, 32'h13, 32'h0, r, e, lat);
      chk("ld_byte13_zx", r, 32'h000000DE);
      access(0, 1'b0, OP_DMEM_BYTE, 1'b0, 32'h10, 32'h0, r, e, lat);
      chk("ld_byte10_sx", r, 32'hFFFFFFEF);

      access(0, 1'b1, OP_DMEM_HALF, 1'b0, 32'h12, 32'h00001234, r, e, lat);
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h10, 32'h0, r, e, lat);
      chk("half_merge", r, 32'h1234BEEF);
      access(0, 1'b0, OP_DMEM_HALF, 1'b1, 32'h12, 32'h0, r, e, lat);
      chk("ld_half12", r, 32'h00001234);
      access(0, 1'b0, OP_DMEM_HALF, 1'b0, 32'h10, 32'h0, r, e, lat);
      chk("ld_half10_sx", r, 32'hFFFFBEEF);
      access(0, 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, r, e, lat);
      chk("size11_as_word", r, 32'h1234BEEF);

`ifdef DMEM_MISALIGN_TRAP_EN
      access(0, 1'b1, OP_DMEM_WORD, 1'b0, 32'h11, 32'hCAFEF00D, r, e, lat);
      chk("mis_st_err", {31'b0, e}, 32'd1);
      chk("mis_st_lat", lat, 32'd2);
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h10, 32'h0, r, e, lat);
      chk("mis_st_nowrite", r, 32'h1234BEEF);
      chk("aligned_err", {31'b0, e}, 32'd0);
      access(0, 1'b0, OP_DMEM_HALF, 1'b0, 32'h11, 32'h0, r, e, lat);
      chk("mis_ld_err", {31'b0, e}, 32'd1);
      chk("mis_ld_rdata", r, 32'd0);
`else
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h11, 32'h0, r, e, lat);
      chk("force_align_word", r, 32'h1234BEEF);
      chk("force_align_err", {31'b0, e}, 32'd0);
      access(0, 1'b0, OP_DMEM_HALF, 1'b1, 32'h13, 32'h0, r, e, lat);
      chk("force_align_half", r, 32'h00001234);
      access(0, 1'b1, OP_DMEM_HALF, 1'b0, 32'h11, 32'h00005678, r, e, lat);
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h10, 32'h0, r, e, lat);
      chk("force_align_st", r, 32'h12345678);
`endif

      access(0, 1'b1, OP_DMEM_WORD, 1'b0, 32'h20, 32'h11111111, r, e, lat);
      // reset while the store sits in WAIT
      @(negedge clk);
      req[0] = 1'b1; wr = 1'b1; size = OP_DMEM_WORD; addr = 32'h20; wdata = 32'h22222222;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0; req[0] = 1'b0;
      #1;
      chk("rst_wait_ready", {31'b0, rdy[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // reset while the store sits in RESP, before its commit edge
      @(negedge clk);
      req[0] = 1'b1; wdata = 32'h33333333;
      @(posedge clk); @(negedge clk); @(negedge clk);
      chk("resp_before_rst", {31'b0, rdy[0]}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_resp_ready", {31'b0, rdy[0]}, 32'd0);
      req[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h20, 32'h0, r, e, lat);
      chk("rst_no_write", r, 32'h11111111);

      access(0, 1'b1, OP_DMEM_BYTE, 1'b0, 32'h22, 32'h000000AB, r, e, lat);
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h20, 32'h0, r, e, lat);
      chk("st_byte_lane", r, 32'h11AB1111);
      access(0, 1'b0, OP_DMEM_BYTE, 1'b0, 32'h22, 32'h0, r, e, lat);
      chk("ld_byte22_sx", r, 32'hFFFFFFAB);

      // request dropped after accept still completes
      @(negedge clk);
      req[0] = 1'b1; wr = 1'b1; size = OP_DMEM_WORD; addr = 32'h44; wdata = 32'h00000077;
      @(posedge clk); @(negedge clk);
      req[0] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (rdy[0] === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      chk("drop_req_completes", {31'b0, seen}, 32'd1);
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h44, 32'h0, r, e, lat);
      chk("drop_req_stored", r, 32'h00000077);

      access(0, 1'b1, OP_DMEM_WORD, 1'b0, 32'h0, 32'hA5A5A5A5, r, e, lat);
      access(0, 1'b1, OP_DMEM_WORD, 1'b0, 32'h1000, 32'h5A5A5A5A, r, e, lat);
      access(0, 1'b0, OP_DMEM_WORD, 1'b0, 32'h0, 32'h0, r, e, lat);
      chk("wrap_alias", r, 32'h5A5A5A5A);

      access(1, 1'b1, OP_DMEM_WORD, 1'b0, 32'h40, 32'h0BADF00D, r, e, lat);
      chk("w0_st_lat", lat, 32'd1);
      access(1, 1'b0, OP_DMEM_WORD, 1'b0, 32'h40, 32'h0, r, e, lat);
      chk("w0_ld_lat", lat, 32'd1);
      chk("w0_ld", r, 32'h0BADF00D);
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (rdy[1] === 1'b1) pulses++;
      end
      chk("w0_no_extra_pulse", pulses, 32'd0);

      access(2, 1'b1, OP_DMEM_HALF, 1'b0, 32'h42, 32'h0000C3C3, r, e, lat);
      chk("w3_st_lat", lat, 32'd4);
      access(2, 1'b0, OP_DMEM_HALF, 1'b0, 32'h42, 32'h0, r, e, lat);
      chk("w3_ld_lat", lat, 32'd4);
      chk("w3_ld", r, 32'hFFFFC3C3);
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (rdy[2] === 1'b1) pulses++;
      end
      chk("w3_no_extra_pulse", pulses, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
